// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for four requesters sharing one mux-steered port.
// Registered one-hot grant, mux select and busy flag, with an optional per-owner hold limit.
module mux4_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam bit          HOLD_EN   = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [3:0] owner_mask;
  logic [3:0] others;
  logic [3:0] cand;
  logic       owner_req;
  logic       hold_hit;
  logic       release_grant;
  logic       arbitrate;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] scan_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;

    owner_mask    = 4'b0001 << sel_q;
    others        = req & ~owner_mask;
    owner_req     = req[sel_q];
    hold_hit      = HOLD_EN && (hold_q == HOLD_W'(HOLD_LAST));
    release_grant = !owner_req || hold_hit;
    arbitrate     = (state_q == IDLE) || release_grant;

    // A hold-limit expiry hands over only when someone else is waiting
    cand = req;
    if ((state_q == GRANT) && owner_req && hold_hit && (|others)) begin
      cand = others;
    end

    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end

    if (arbitrate) begin
      if (win_found) begin
        state_d = GRANT;
        gnt_d   = 4'b0001 << win_idx;
        sel_d   = win_idx;
        busy_d  = 1'b1;
        ptr_d   = win_idx + 2'd1;
        hold_d  = '0;
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: doc/mux4_arbiter.md
Name: mux4_arbiter

Overview:
- Round-robin arbiter sharing one 4-input mux-steered resource (e.g. a memory or bus port) among four requesters.
- Drives the 2-bit select of a 4:1 data mux together with a one-hot grant vector.
- Owner keeps the grant while its request stays asserted, up to a configurable hold limit; grants then rotate fairly.
- Sits between the requesters (fetch, load/store, debug, DMA) and the shared port's input mux.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles per owner; 0 disables the limit
HOLD_W, 5, hold counter width; must satisfy 2^HOLD_W >= MAX_HOLD

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req  input  4  request per requester; bit i = requester i; level-sensitive
gnt  output  4  registered one-hot grant; all zeros when idle
sel  output  2  index of current or last owner; drives 4:1 mux select
busy  output  1  registered; 1 while any grant is active (equals OR of gnt)

Behaviour:
- Reset (async, immediate): gnt=0000, sel=00, busy=0, rotation pointer ptr=0 (requester 0 scanned first), hold_cnt=0, state IDLE.
- Two states:
  - IDLE: gnt=0.
  - GRANT: exactly one gnt bit set; owner = sel.
- Release condition, evaluated only in GRANT: req[owner]==0, OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1).
- Arbitration happens at a rising edge when in IDLE, or when in GRANT with release true.
  - Candidates = req.
  - On a hold-limit release with another req bit set, mask the owner out of the candidates.
  - Winner = first set candidate scanning ptr, ptr+1, ... mod 4.
  - Winner found: gnt=onehot(winner), sel=winner, busy=1, ptr=winner+1 mod 4, hold_cnt=0, state GRANT.
  - No candidate: gnt=0, busy=0, state IDLE; sel and ptr hold their values.
- GRANT without release: gnt/sel unchanged, hold_cnt increments by 1.
- Latency: req asserted in cycle N (sampled at edge N+1) -> gnt visible after edge N+1; one cycle request-to-grant.
- Handover is back-to-back. The new owner's gnt rises on the same edge the old owner's gnt falls, with no idle bubble when other requests are pending.
- Sole requester reaching the hold limit is re-granted on the same edge: gnt unchanged, hold_cnt reset to 0, ptr=owner+1.
- With MAX_HOLD=N, an owner holding req continuously keeps gnt for exactly N cycles while others request.
- Non-owner req bits toggling while a grant is active have no effect until the next arbitration edge.
- Owner dropping req releases the grant at the next edge; there is no early-release path within the cycle.
- gnt is always one-hot or zero; sel always equals the index of the set gnt bit whenever busy=1.
- Reset mid-grant: outputs return to reset values immediately, independent of clk; the arbiter restarts from ptr=0.
- No combinational path from req to gnt, sel or busy.

Test Plan:
1. After reset, req=0001 -> next edge gnt=0001, sel=00, busy=1; drop req -> next edge gnt=0000, busy=0, sel stays 00.
2. After reset, req=1111 with each owner dropping its req bit one cycle after grant -> grant order 0001, 0010, 0100, 1000; each handover has no idle cycle.
3. MAX_HOLD=4, req=0011 held constant -> gnt=0001 for exactly 4 cycles, then 0010 for 4 cycles, then 0001, alternating indefinitely.
4. MAX_HOLD=4, req=0100 held alone for 10 cycles -> gnt=0100, sel=10 continuously with no zero cycle; hold_cnt wraps 0..3.
5. Owner 2 holds grant and requester 0 asserts; owner 2 releases -> next grant is 1000 if req[3] is set, else 0001 (scan starts at ptr=3).
6. Assert reset asynchronously mid-grant with gnt=1000 -> gnt=0000, sel=00, busy=0 before the next clk edge; after deassert, req=1010 -> gnt=0010.
